// File: rtl/lenet_predict_udiv_9ns_6ns_9_seq.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per cycle,
// valid/ready handshake on both sides, a single division in flight.
module lenet_predict_udiv_9ns_6ns_9_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned DIVIDEND_W = 9,
  parameter int unsigned DIVISOR_W  = 6
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned N = DIVIDEND_W;
  localparam int unsigned M = DIVISOR_W;
  // ID is an instance tag only; it is folded in here as a zero term.
  localparam int unsigned CNT_W = ((N > 1) ? $clog2(N) : 1) + (ID & 0);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     work_q, work_d;
  logic [M-1:0]     dvs_q, dvs_d;
  logic [M-1:0]     pr_q, pr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     quot_q, quot_d;
  logic [M-1:0]     rem_q, rem_d;
  logic             dbz_out_q, dbz_out_d;

  // One restoring step. work_q holds the dividend bits still to be consumed
  // in its upper part and the quotient bits produced so far in its lower part.
  logic [M:0]   pr_sh;
  logic         qbit;
  logic [M-1:0] pr_new;
  logic [N-1:0] work_new;

  always_comb begin
    pr_sh    = {pr_q, work_q[N-1]};
    qbit     = (pr_sh >= {1'b0, dvs_q});
    // After a restore the partial remainder is below the divisor, so M bits
    // hold it; with a zero divisor the truncated value is never reported.
    pr_new   = qbit ? M'(pr_sh - {1'b0, dvs_q}) : pr_sh[M-1:0];
    work_new = {work_q[N-2:0], qbit};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_out_d   = dbz_out_q;

    unique case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid) begin
          work_d     = dividend;
          dvs_d      = divisor;
          pr_d       = '0;
          cnt_d      = '0;
          dbz_d      = (divisor == '0);
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        work_d = work_new;
        pr_d   = pr_new;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          quot_d      = dbz_q ? '1 : work_new;
          rem_d       = dbz_q ? '0 : pr_new;
          dbz_out_d   = dbz_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight result.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_out_q   <= dbz_out_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_lenet_predict_udiv_9ns_6ns_9_seq.sv
// Directed-vector and randomised bench for the sequential 9/6 unsigned divider.
module tb_lenet_predict_udiv_9ns_6ns_9_seq;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] dividend;
  logic [5:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;

  int total  = 0;
  int passed = 0;

  lenet_predict_udiv_9ns_6ns_9_seq #(
    .ID(1), .DIVIDEND_W(9), .DIVISOR_W(6)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [8:0] a;
    logic [5:0] b;
    logic [8:0] q;
    logic [5:0] r;
    logic       z;
  } vec_t;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // out_valid and in_ready must never be high together.
  always @(negedge ap_clk) begin
    if (ap_rst === 1'b0) begin
      total++;
      if (!(out_valid === 1'b1 && in_ready === 1'b1)) passed++;
      else $display("FAIL handshake_excl: got out_valid=1 in_ready=1 expected not both");
    end
  end

  task automatic start_op(input logic [8:0] a, input logic [5:0] b);
    int w = 0;
    @(negedge ap_clk);
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge ap_clk);
      w++;
    end
    if (w >= 40) chk("start_timeout", 0, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    dividend = 9'($urandom);
    divisor  = 6'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [8:0] a, input logic [5:0] b,
                           input logic [8:0] eq, input logic [5:0] er, input logic ez,
                           input int hold);
    int lat;
    start_op(a, b);
    wait_done(lat);
    chk({nm, "_latency"}, lat, 9);
    chk({nm, "_quotient"}, int'(quotient), int'(eq));
    chk({nm, "_remainder"}, int'(remainder), int'(er));
    chk({nm, "_dbz"}, int'(div_by_zero), int'(ez));
    repeat (hold) begin
      @(posedge ap_clk);
      #1;
    end
    drain();
  endtask

  initial begin
    vec_t vecs[9];
    int   lat;
    bit   leaked;

    vecs[0] = '{a: 9'd200, b: 6'd7,  q: 9'd28,  r: 6'd4, z: 1'b0};
    vecs[1] = '{a: 9'd511, b: 6'd1,  q: 9'd511, r: 6'd0, z: 1'b0};
    vecs[2] = '{a: 9'd5,   b: 6'd63, q: 9'd0,   r: 6'd5, z: 1'b0};
    vecs[3] = '{a: 9'd0,   b: 6'd13, q: 9'd0,   r: 6'd0, z: 1'b0};
    vecs[4] = '{a: 9'd511, b: 6'd63, q: 9'd8,   r: 6'd7, z: 1'b0};
    vecs[5] = '{a: 9'd300, b: 6'd0,  q: 9'd511, r: 6'd0, z: 1'b1};
    vecs[6] = '{a: 9'd400, b: 6'd3,  q: 9'd133, r: 6'd1, z: 1'b0};
    vecs[7] = '{a: 9'd0,   b: 6'd0,  q: 9'd511, r: 6'd0, z: 1'b1};
    vecs[8] = '{a: 9'd62,  b: 6'd63, q: 9'd0,   r: 6'd62, z: 1'b0};

    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, i % 3);

    // Backpressure: result held for 20 cycles while in_valid toggles.
    start_op(9'd100, 6'd9);
    wait_done(lat);
    chk("bp_latency", lat, 9);
    for (int c = 0; c < 20; c++) begin
      in_valid = ~in_valid;
      dividend = 9'd50;
      divisor  = 6'd5;
      @(posedge ap_clk);
      #1;
      chk($sformatf("bp_hold%0d", c),
          int'({out_valid, in_ready, div_by_zero, quotient, remainder}),
          int'({1'b1, 1'b0, 1'b0, 9'd11, 6'd1}));
    end
    in_valid = 1'b0;
    drain();
    chk("bp_drain_in_ready", int'(in_ready), 1);
    chk("bp_drain_out_valid", int'(out_valid), 0);
    run_check("bp_next", 9'd50, 6'd5, 9'd10, 6'd0, 1'b0, 0);

    // Reset in the middle of CALC discards the division.
    start_op(9'd400, 6'd3);
    repeat (3) begin
      @(posedge ap_clk);
      #1;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    leaked = 1'b0;
    repeat (12) begin
      @(posedge ap_clk);
      #1;
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    chk("midrst_no_result", int'(leaked), 0);
    run_check("midrst_after", 9'd400, 6'd3, 9'd133, 6'd1, 1'b0, 0);

    // Randomised back-to-back traffic against an arithmetic scoreboard.
    for (int k = 0; k < 1000; k++) begin
      logic [8:0] a;
      logic [5:0] b;
      logic [8:0] eq;
      logic [5:0] er;
      a  = 9'($urandom_range(0, 511));
      b  = 6'($urandom_range(0, 63));
      eq = (b == 0) ? 9'd511 : 9'(a / b);
      er = (b == 0) ? 6'd0   : 6'(a % b);
      run_check($sformatf("rand%0d", k), a, b, eq, er, (b == 0), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lenet_predict_udiv_9ns_6ns_9_seq.md
Name: lenet_predict_udiv_9ns_6ns_9_seq

Overview:
- Sequential unsigned integer divider, the inverse of the team's 5x6->9 unsigned multiplier.
- Recovers a quotient and remainder from a 9-bit product-width value and a 6-bit divisor.
- Used by the LeNet predict datapath for average-pool / index normalisation.
- Restoring radix-2 algorithm: one quotient bit per cycle, valid/ready handshake on both sides, one division in flight at a time.

Parameters:
- ID, 1, instance tag; no functional effect.
- DIVIDEND_W, 9, dividend width and quotient width (N).
- DIVISOR_W, 6, divisor width and remainder width (M).

Ports:
- ap_clk  in  1  clock; all state changes on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  dividend/divisor presented.
- in_ready  out  1  block can accept an operand pair.
- dividend  in  DIVIDEND_W  unsigned dividend.
- divisor  in  DIVISOR_W  unsigned divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- quotient  out  DIVIDEND_W  unsigned quotient.
- remainder  out  DIVISOR_W  unsigned remainder.
- div_by_zero  out  1  result came from divisor==0.

Behaviour:
- Reset (ap_rst=1 at an edge):
  - State goes to IDLE; in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter=0.
  - Reset overrides everything, including mid-CALC and pending DONE. Any in-flight result is discarded and never presented.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the operands are captured. The dividend goes into a shift register and the divisor is registered. The partial remainder (M+1 bits) is cleared, counter=0, and state goes to CALC.
  - div_by_zero_r is latched as (divisor==0).
- State CALC:
  - in_ready=0.
  - Each edge does one step:
    - pr = {pr[M-1:0], dividend_msb}.
    - If pr >= {1'b0, divisor}, then pr -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
    - The quotient bit shifts into the LSB of the quotient register, the dividend shifts left, and counter increments.
  - After the N-th CALC edge (counter reaches N-1 and is consumed), state goes to DONE and out_valid=1.
  - Latency: out_valid is first high exactly N=9 cycles after the accepting edge.
- State DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero stay stable while out_valid=1 && out_ready=0 (backpressure holds indefinitely).
  - On an edge with out_ready=1, state goes to IDLE and out_valid=0.
  - Throughput: at most one division per N+2 cycles. There is no overlap of accept with drain.
- Divide by zero:
  - Runs the same N cycles.
  - Reported quotient is forced to all ones (511), remainder is forced to 0, and div_by_zero=1.
  - Internal pr overflow from the degenerate iterations must not leak to the outputs.
- Arithmetic:
  - Purely unsigned. pr is M+1 bits so the compare never truncates.
  - The final remainder is pr[M-1:0], which is always < divisor when divisor != 0.
- Input handling:
  - in_valid while not IDLE is ignored; operands are not sampled and there is no queueing.
  - dividend/divisor changes after acceptance have no effect.
- Invariants: out_valid and in_ready are never both high. Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then accept 200/7 -> out_valid high exactly 9 cycles after the accept edge; quotient=28, remainder=4, div_by_zero=0.
- Boundary operands 511/1 -> 511,0; 5/63 -> 0,5; 0/13 -> 0,0; 511/63 -> 8,7.
- Divide by zero, 300/0 -> quotient=511, remainder=0, div_by_zero=1, same 9-cycle latency.
- Backpressure: hold out_ready=0 for 20 cycles after 100/9 -> outputs stay at 11,1 with out_valid=1. Toggle in_valid with 50/5 during this window -> ignored. After out_ready=1, in_ready=1 the next cycle and 50/5 -> 10,0 is then accepted normally.
- Reset mid-operation: assert ap_rst at CALC cycle 4 of 400/3 -> next cycle in_ready=1, out_valid=0, outputs 0. A subsequent 400/3 -> 133,1 after the full 9 cycles.
- Randomised back-to-back: 1000 random pairs with random out_ready -> every result equals the scoreboard (q=a/b, r=a%b; b=0 gives 511,0,1). Latency is always 9, and out_valid and in_ready are never both high.
